data_mem_responder: RTL and testbench

Handshaked data-memory responder serving the processor's MEM-stage load/store requests. Accepts one word-wide read or write per transaction and returns a one-cycle response after a fixed, parameterised latency. Drives `busy` so the pipeline can freeze while a request is outstanding. Replaces the single-cycle data memory when memory latency has to be modelled.

---
 rtl/data_mem_responder.sv | 151 +++++++++++++++
 tb/tb_data_mem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for MEM-stage loads/stores with a modelled access time.
// Latency: response strobe LATENCY cycles after the accepting edge, held for one cycle.
// Backpressure: req_ready low (and busy high) while a request is outstanding in WAIT.
//
// Ports:
//   clk        - clock, all state on the rising edge
//   reset      - asynchronous active-low reset
//   req_valid / req_we / req_addr / req_wdata - request (store when req_we=1)
//   req_ready  - request accepted on an edge where req_valid & req_ready
//   rsp_valid  - one-cycle response strobe; rsp_rdata / rsp_err qualify it
//   busy       - high while waiting on the memory, used as the pipeline freeze
//
// Build option: define DMEM_ERR_CHECK_EN to reject out-of-range and misaligned
// requests (rsp_err=1, store dropped, load returns 0). Without it the word index
// wraps modulo DEPTH, the low address bits are ignored and rsp_err stays 0.
module data_mem_responder #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 1024,
    parameter int LATENCY   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic              accept;
    logic              resp_enter;

    logic [ADDR_W-1:0] offset;
    logic [IDX_W-1:0]  idx_d;
    logic              err_d;

    logic              we_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;

    logic [DATA_W-1:0] mem [DEPTH];

    assign accept     = req_valid & req_ready;
    // The memory access happens on the edge that moves WAIT -> RESP.
    assign resp_enter = (state == WAIT) && (cnt == 4'd0);

    // Byte offset from the window base, unsigned wrap at address width.
    assign offset = req_addr - ADDR_W'(BASE_ADDR);
    assign idx_d  = offset[IDX_W+1:2];

`ifdef DMEM_ERR_CHECK_EN
    // Full word index must land inside the array and the address be word aligned.
    assign err_d = (offset[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH)) || (req_addr[1:0] != 2'b00);

    logic unused_offset_bits;
    assign unused_offset_bits = ^offset[1:0];
`else
    // Wrapping build: only the low index bits address the array.
    assign err_d = 1'b0;

    logic unused_offset_bits;
    assign unused_offset_bits = ^{offset[ADDR_W-1:IDX_W+2], offset[1:0]};
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? WAIT : IDLE;
            WAIT:    state_nxt = (cnt == 4'd0) ? RESP : WAIT;
            RESP:    state_nxt = accept ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        req_ready = (state == IDLE) || (state == RESP);
        busy      = (state == WAIT);
        rsp_valid = (state == RESP);
    end

    // Request capture and latency countdown.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            cnt     <= 4'(LATENCY - 1);
            we_q    <= req_we;
            idx_q   <= idx_d;
            wdata_q <= req_wdata;
            err_q   <= err_d;
        end else if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Response payload: loaded entering RESP, cleared leaving it so it is
    // zero whenever rsp_valid is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (resp_enter) begin
            rsp_rdata <= (!we_q && !err_q) ? mem[idx_q] : '0;
            rsp_err   <= err_q;
        end else if (state == RESP) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end
    end

    // Storage is not reset; a store aborted by reset never reaches this edge.
    always_ff @(posedge clk) begin
        if (resp_enter && we_q && !err_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int LAT = 2;

`ifdef DMEM_ERR_CHECK_EN
    localparam bit EC = 1'b1;
`else
    localparam bit EC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    logic        req_valid1 = 1'b0;
    logic        req_we1 = 1'b0;
    logic [31:0] req_addr1 = 32'd0;
    logic [31:0] req_wdata1 = 32'd0;
    logic        req_ready1;
    logic        rsp_valid1;
    logic [31:0] rsp_rdata1;
    logic        rsp_err1;
    logic        busy1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    data_mem_responder #(.LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    data_mem_responder #(.LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_we(req_we1), .req_addr(req_addr1), .req_wdata(req_wdata1),
        .req_ready(req_ready1), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
        .rsp_err(rsp_err1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transaction on the LATENCY=2 instance; starts and ends at a negedge with the DUT idle.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        int n;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_wdata = 32'd0;
        chk({tag, " busy"}, 32'(busy), 32'd1);
        chk({tag, " ready_wait"}, 32'(req_ready), 32'd0);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(LAT));
        chk({tag, " rdata"}, rsp_rdata, exp_rd);
        chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, " busy_resp"}, 32'(busy), 32'd0);
        chk({tag, " ready_resp"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        chk({tag, " valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, " rdata_clr"}, rsp_rdata, 32'd0);
    endtask

    logic [31:0] tb_addr [4];
    logic        tb_we   [4];
    logic [31:0] tb_wd   [4];
    logic [31:0] tb_exp  [4];

    initial begin
        int n;
        int acc;
        int last;
        bit saw;

        // Reset state
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst rsp_err", 32'(rsp_err), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst req_ready", 32'(req_ready), 32'd1);

        // Store then load
        xact("st1024", 1'b1, 32'd1024, 32'hDEADBEEF, 32'd0, 1'b0);
        xact("ld1024", 1'b0, 32'd1024, 32'd0, 32'hDEADBEEF, 1'b0);

        // Preload for back-to-back
        xact("st1028", 1'b1, 32'd1028, 32'd1, 32'd0, 1'b0);
        xact("st1032", 1'b1, 32'd1032, 32'd2, 32'd0, 1'b0);
        xact("st1036", 1'b1, 32'd1036, 32'd3, 32'd0, 1'b0);

        // Back-to-back loads with req_valid held high
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd1028;
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        last = acc;
        req_addr = 32'd1032;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (rsp_valid !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("b2b valid", 32'(rsp_valid), 32'd1);
            chk("b2b gap", 32'(cyc - last), (i == 0) ? 32'(LAT) : 32'(LAT + 1));
            last = cyc;
            chk("b2b rdata", rsp_rdata, 32'(i + 1));
            chk("b2b ready", 32'(req_ready), 32'd1);
            if (i == 2) req_valid = 1'b0;
            @(negedge clk);
            if (i == 0) req_addr = 32'd1036;
        end
        chk("b2b idle valid", 32'(rsp_valid), 32'd0);
        chk("b2b idle busy", 32'(busy), 32'd0);

        // Out of range: 1280 is word 64
        xact("st1280", 1'b1, 32'd1280, 32'h55, 32'd0, EC);
        xact("ld1280", 1'b0, 32'd1280, 32'd0, EC ? 32'd0 : 32'h55, EC);
        xact("ld1024_oor", 1'b0, 32'd1024, 32'd0, EC ? 32'hDEADBEEF : 32'h55, 1'b0);

        // Misaligned store to 1026
        xact("st1026", 1'b1, 32'd1026, 32'h1234, 32'd0, EC);
        xact("ld1024_mis", 1'b0, 32'd1024, 32'd0, EC ? 32'hDEADBEEF : 32'h1234, 1'b0);

        // Reset abort of a store during WAIT
        xact("st1040_pre", 1'b1, 32'd1040, 32'h1111, 32'd0, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd1040; req_wdata = 32'hAAAA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
        @(posedge clk);
        #1;
        chk("abort busy_before", 32'(busy), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort ready", 32'(req_ready), 32'd1);
        chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort rdata", rsp_rdata, 32'd0);
        chk("abort err", 32'(rsp_err), 32'd0);
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) saw = 1'b1;
        end
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) saw = 1'b1;
        end
        chk("abort no_rsp", 32'(saw), 32'd0);
        xact("ld1040", 1'b0, 32'd1040, 32'd0, 32'h1111, 1'b0);

        // LATENCY=1 instance: held-valid sequence, one request every 2 cycles
        tb_we[0] = 1'b1; tb_addr[0] = 32'd1024; tb_wd[0] = 32'h77; tb_exp[0] = 32'd0;
        tb_we[1] = 1'b1; tb_addr[1] = 32'd1028; tb_wd[1] = 32'h88; tb_exp[1] = 32'd0;
        tb_we[2] = 1'b0; tb_addr[2] = 32'd1024; tb_wd[2] = 32'd0;  tb_exp[2] = 32'h77;
        tb_we[3] = 1'b0; tb_addr[3] = 32'd1028; tb_wd[3] = 32'd0;  tb_exp[3] = 32'h88;
        req_valid1 = 1'b1; req_we1 = tb_we[0]; req_addr1 = tb_addr[0]; req_wdata1 = tb_wd[0];
        @(posedge clk);
        @(negedge clk);
        last = cyc;
        req_we1 = tb_we[1]; req_addr1 = tb_addr[1]; req_wdata1 = tb_wd[1];
        chk("l1 busy", 32'(busy1), 32'd1);
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (rsp_valid1 !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("l1 valid", 32'(rsp_valid1), 32'd1);
            chk("l1 gap", 32'(cyc - last), (i == 0) ? 32'd1 : 32'd2);
            last = cyc;
            chk("l1 rdata", rsp_rdata1, tb_exp[i]);
            chk("l1 err", 32'(rsp_err1), 32'd0);
            if (i == 3) req_valid1 = 1'b0;
            @(negedge clk);
            if (i + 2 < 4) begin
                req_we1 = tb_we[i + 2]; req_addr1 = tb_addr[i + 2]; req_wdata1 = tb_wd[i + 2];
            end
        end
        chk("l1 idle valid", 32'(rsp_valid1), 32'd0);
        chk("l1 idle ready", 32'(req_ready1), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
